// File: rtl/hps_ext_regs.sv
// HPS command/status endpoint on EXT_BUS: status snapshot reads, sticky control flags, event counter.
// Latency: io_dout/dout_en one cycle after the strobe; flags and ctrl_wr one cycle after the SET data strobe.
// Backpressure: none; each io_strobe consumes exactly one word.
module hps_ext_regs #(
    parameter logic [7:0] CMD_BASE = 8'hF0,
    parameter int         N_STATUS = 6,
    parameter int         N_CTRL   = 3
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    inout  wire  [35:0]             EXT_BUS,
    input  logic                    hps_rise,
    input  logic [16*N_STATUS-1:0]  status_in,
    input  logic [N_CTRL-1:0]       ctrl_ack,
    output logic [N_CTRL-1:0]       ctrl_flags,
    output logic [N_CTRL-1:0]       ctrl_wr
);

    localparam int              WC_W      = $clog2(N_STATUS + 2);
    localparam logic [WC_W-1:0] WC_MAX    = WC_W'(N_STATUS + 1);
    localparam logic [15:0]     OP_STATUS = {8'd0, CMD_BASE};
    localparam logic [15:0]     OP_CTRL   = OP_STATUS + 16'd1;
    localparam logic [15:0]     OP_SET0   = OP_STATUS + 16'd2;
    localparam logic [15:0]     OP_END    = OP_SET0 + 16'(N_CTRL);

    logic [15:0]             io_dout;
    logic                    dout_en;
    logic [15:0]             io_din;
    logic                    io_strobe;
    logic                    io_enable;

    assign EXT_BUS[15:0] = io_dout;
    assign EXT_BUS[32]   = dout_en;
    assign io_din        = EXT_BUS[31:16];
    assign io_strobe     = EXT_BUS[33];
    assign io_enable     = EXT_BUS[34];

    logic [WC_W-1:0]         wc;
    logic [15:0]             cmd;
    logic [16*N_STATUS-1:0]  snap;
    logic                    armed;
    logic [7:0]              evt_cnt;
    logic                    rise_q;
    logic                    rise_qq;

    logic                    strobe_ok;
    logic                    din_in_win;
    logic [15:0]             snap_word;
    logic [N_CTRL-1:0]       wr_set;

    assign strobe_ok  = armed & io_enable & io_strobe;
    assign din_in_win = (io_din >= OP_STATUS) && (io_din < OP_END);

    // Word k of a GET_STATUS reply is snapshot word k-1; past the last word it reads 0.
    always_comb begin
        snap_word = 16'd0;
        for (int k = 0; k < N_STATUS; k++) begin
            if (wc == WC_W'(k + 1)) snap_word = snap[16*k +: 16];
        end
    end

    always_comb begin
        wr_set = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            wr_set[i] = strobe_ok && (wc == WC_W'(1)) && (cmd == OP_SET0 + 16'(i));
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ctrl_flags <= '0;
            ctrl_wr    <= '0;
            io_dout    <= 16'd0;
            dout_en    <= 1'b0;
            evt_cnt    <= 8'd0;
            wc         <= '0;
            cmd        <= 16'd0;
            snap       <= '0;
            armed      <= 1'b0;
            rise_q     <= hps_rise;
            rise_qq    <= hps_rise;
        end else begin
            rise_q  <= hps_rise;
            rise_qq <= rise_q;
            if (rise_q != rise_qq) evt_cnt <= evt_cnt + 8'd1;

            // A write in the same cycle as an ack wins for that flag only.
            ctrl_wr    <= wr_set;
            ctrl_flags <= (ctrl_flags & ~ctrl_ack & ~wr_set) | (wr_set & {N_CTRL{io_din[0]}});

            if (!io_enable) begin
                armed   <= 1'b1;
                dout_en <= 1'b0;
                io_dout <= 16'd0;
                wc      <= '0;
                cmd     <= 16'd0;
            end else if (strobe_ok) begin
                if (wc != WC_MAX) wc <= wc + WC_W'(1);
                if (wc == '0) begin
                    cmd     <= io_din;
                    dout_en <= din_in_win;
                    io_dout <= din_in_win ? {8'd0, evt_cnt} : 16'd0;
                    if (io_din == OP_STATUS) snap <= status_in;
                end else begin
                    io_dout <= 16'd0;
                    if (cmd == OP_STATUS)
                        io_dout <= snap_word;
                    else if (cmd == OP_CTRL && wc == WC_W'(1))
                        io_dout <= 16'(ctrl_flags);
                end
            end
        end
    end

endmodule

// File: tb/tb_hps_ext_regs.sv
// Scoreboard bench for hps_ext_regs: expected replies are queued as words are driven and checked on output.
module tb_hps_ext_regs;

    localparam int N_STATUS = 6;
    localparam int N_CTRL   = 3;

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic                   hps_rise;
    logic [16*N_STATUS-1:0] status_in;
    logic [N_CTRL-1:0]      ctrl_ack;
    logic [N_CTRL-1:0]      ctrl_flags;
    logic [N_CTRL-1:0]      ctrl_wr;
    logic [15:0]            io_din;
    logic                   io_strobe;
    logic                   io_enable;

    wire  [35:0]            ext_bus;
    wire  [15:0]            io_dout = ext_bus[15:0];
    wire                    dout_en = ext_bus[32];

    assign ext_bus[31:16] = io_din;
    assign ext_bus[33]    = io_strobe;
    assign ext_bus[34]    = io_enable;
    assign ext_bus[35]    = 1'b0;

    hps_ext_regs #(.CMD_BASE(8'hF0), .N_STATUS(N_STATUS), .N_CTRL(N_CTRL)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .EXT_BUS    (ext_bus),
        .hps_rise   (hps_rise),
        .status_in  (status_in),
        .ctrl_ack   (ctrl_ack),
        .ctrl_flags (ctrl_flags),
        .ctrl_wr    (ctrl_wr)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       tag;
        logic [15:0] dout;
        logic        en;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  cnt_m = 8'd0;
    logic [15:0] snap_m [N_STATUS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one strobed word; compare the registered reply on the following negedge.
    task automatic xword(input string tag, input logic [15:0] w, input logic [15:0] ed,
                         input logic ee, input logic [N_CTRL-1:0] ack = '0);
        exp_t e;
        e.tag  = tag;
        e.dout = ed;
        e.en   = ee;
        sb.push_back(e);
        @(negedge clk_sys);
        io_din    = w;
        io_strobe = 1'b1;
        ctrl_ack  = ack;
        @(negedge clk_sys);
        io_strobe = 1'b0;
        ctrl_ack  = '0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_dout"}, {16'd0, io_dout}, {16'd0, e.dout});
            check({e.tag, "_en"}, {31'd0, dout_en}, {31'd0, e.en});
        end
    endtask

    task automatic new_xfer();
        @(negedge clk_sys);
        io_enable = 1'b0;
        @(negedge clk_sys);
        io_enable = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        hps_rise  = 1'b0;
        ctrl_ack  = '0;
        io_din    = 16'd0;
        io_strobe = 1'b0;
        io_enable = 1'b1;
        for (int k = 0; k < N_STATUS; k++) status_in[16*k +: 16] = 16'hA000 + 16'(k);
        repeat (3) @(negedge clk_sys);
        check("rst_flags", 32'(ctrl_flags), 32'd0);
        check("rst_wr", 32'(ctrl_wr), 32'd0);
        check("rst_dout", 32'(io_dout), 32'd0);
        check("rst_en", 32'(dout_en), 32'd0);
        reset = 1'b0;

        // Unarmed: strobes during the interrupted transfer are ignored.
        xword("unarmed_w0", 16'h0003, 16'h0000, 1'b0);
        xword("unarmed_w1", 16'h00F0, 16'h0000, 1'b0);
        new_xfer();
        xword("armed_op", 16'h00F0, {8'd0, cnt_m}, 1'b1);
        @(negedge clk_sys);
        io_enable = 1'b0;
        @(negedge clk_sys);
        check("idle_dout", 32'(io_dout), 32'd0);
        check("idle_en", 32'(dout_en), 32'd0);

        // GET_STATUS with coherent snapshot.
        status_in[15:0] = 16'h1234;
        for (int k = 0; k < N_STATUS; k++) snap_m[k] = status_in[16*k +: 16];
        io_enable = 1'b1;
        xword("st_op", 16'h00F0, {8'd0, cnt_m}, 1'b1);
        status_in = '1;
        for (int k = 1; k <= N_STATUS + 3; k++)
            xword($sformatf("st_w%0d", k), 16'h0000, (k <= N_STATUS) ? snap_m[k-1] : 16'h0000, 1'b1);

        // Event counter wraps after 257 edges.
        for (int t = 0; t < 257; t++) begin
            @(negedge clk_sys);
            hps_rise = ~hps_rise;
            cnt_m    = cnt_m + 8'd1;
        end
        repeat (3) @(negedge clk_sys);
        new_xfer();
        xword("evt_op", 16'h00F0, {8'd0, cnt_m}, 1'b1);
        check("evt_model", 32'(cnt_m), 32'd1);

        // SET_CTRL_1 then GET_CTRL.
        new_xfer();
        xword("set1_op", 16'h00F3, {8'd0, cnt_m}, 1'b1);
        xword("set1_dat", 16'h0001, 16'h0000, 1'b1);
        check("set1_flags", 32'(ctrl_flags), 32'b010);
        check("set1_wr", 32'(ctrl_wr), 32'b010);
        @(negedge clk_sys);
        check("set1_wr_end", 32'(ctrl_wr), 32'd0);
        new_xfer();
        xword("getc_op", 16'h00F1, {8'd0, cnt_m}, 1'b1);
        xword("getc_w1", 16'h0000, 16'h0002, 1'b1);
        xword("getc_w2", 16'h0000, 16'h0000, 1'b1);

        // Write beats ack on the same flag; ack on another flag still clears it.
        new_xfer();
        xword("set0_op", 16'h00F2, {8'd0, cnt_m}, 1'b1);
        xword("set0_dat", 16'h0001, 16'h0000, 1'b1);
        check("set0_flags", 32'(ctrl_flags), 32'b011);
        new_xfer();
        xword("race_op", 16'h00F3, {8'd0, cnt_m}, 1'b1);
        xword("race_dat", 16'h0001, 16'h0000, 1'b1, 3'b011);
        check("race_flags", 32'(ctrl_flags), 32'b010);
        ctrl_ack = 3'b010;
        @(negedge clk_sys);
        ctrl_ack = '0;
        check("ack_flags", 32'(ctrl_flags), 32'b000);

        // Out-of-window opcodes leave flags alone.
        new_xfer();
        xword("set2_op", 16'h00F4, {8'd0, cnt_m}, 1'b1);
        xword("set2_dat", 16'h0001, 16'h0000, 1'b1);
        new_xfer();
        xword("lo_op", 16'h00EF, 16'h0000, 1'b0);
        xword("lo_dat", 16'h0000, 16'h0000, 1'b0);
        check("lo_wr", 32'(ctrl_wr), 32'd0);
        new_xfer();
        xword("hi_op", 16'h00F5, 16'h0000, 1'b0);
        xword("hi_dat", 16'h0000, 16'h0000, 1'b0);
        check("hi_wr", 32'(ctrl_wr), 32'd0);
        check("oow_flags", 32'(ctrl_flags), 32'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
